// File: rtl/cnn_pkg.sv
// Shared types for the CNN pixel pipeline (window buffer and conv stage).
// Pixel width, window packing and window-buffer FSM encoding live here.
package cnn_pkg;

    localparam int PIX_W    = 8;
    localparam int WIN_TAPS = 9;
    localparam int WIN_W    = PIX_W * WIN_TAPS;

    typedef logic [PIX_W-1:0] pixel_t;
    typedef logic [WIN_W-1:0] win_t;

    typedef enum logic {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/line_fifo.sv
// Shift-enabled delay line: data leaves DEPTH enabled cycles after entry.
// Ports: clk, rst_n, en (advance), data (input word), delayed (output word).
module line_fifo #(
    parameter int DEPTH = 28,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] delayed
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    ptr;

    // The slot about to be overwritten holds the word written DEPTH
    // enables ago, so read-before-write gives the full delay.
    assign delayed = mem[ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
        end
    end

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr] <= data;
        end
    end

endmodule

// File: rtl/window_buffer.sv
// Raster pixel stream to 3x3 sliding windows (valid region, no padding).
// Ports: clk, rst_n, pix_in/pix_valid/sof in; window/win_valid/frame_done/busy out.
module window_buffer
    import cnn_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    input  logic             sof,
    output logic [WIN_W-1:0] window,
    output logic             win_valid,
    output logic             frame_done,
    output logic             busy
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    state_t        state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [CW-1:0] pcol;
    logic [RW-1:0] prow;
    win_t          taps;
    win_t          shifted;
    pixel_t        lb0_out;
    pixel_t        lb1_out;
    logic          start;
    logic          last_col;
    logic          last_row;
    logic          emit;
    logic          frame_end;

    line_fifo #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_W)
    ) u_lb0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (pix_valid),
        .data    (pix_in),
        .delayed (lb0_out)
    );

    line_fifo #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_W)
    ) u_lb1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (pix_valid),
        .data    (lb0_out),
        .delayed (lb1_out)
    );

    // Position of the pixel on the bus; sof overrides it to (0,0).
    always_comb begin
        start     = pix_valid & sof;
        pcol      = start ? '0 : col;
        prow      = start ? '0 : row;
        last_col  = (pcol == CW'(IMG_W - 1));
        last_row  = (prow == RW'(IMG_H - 1));
        emit      = pix_valid && (prow >= RW'(2)) && (pcol >= CW'(2));
        frame_end = pix_valid && last_col && last_row
                    && (state == S_RUN);
    end

    // Shift the 3x3 window left; new right column is (lb1, lb0, pix).
    always_comb begin
        shifted = '0;
        for (int r = 0; r < 3; r++) begin
            shifted[PIX_W*(3*r)   +: PIX_W] = taps[PIX_W*(3*r+1) +: PIX_W];
            shifted[PIX_W*(3*r+1) +: PIX_W] = taps[PIX_W*(3*r+2) +: PIX_W];
        end
        shifted[PIX_W*2 +: PIX_W] = lb1_out;
        shifted[PIX_W*5 +: PIX_W] = lb0_out;
        shifted[PIX_W*8 +: PIX_W] = pix_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_FILL;
            col        <= '0;
            row        <= '0;
            taps       <= '0;
            window     <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            win_valid  <= emit;
            frame_done <= frame_end;
            if (pix_valid) begin
                taps <= shifted;
                // The output word only changes on a real window, so it
                // stays stable between pulses.
                if (emit) begin
                    window <= shifted;
                end
                busy <= !frame_end;
                col  <= last_col ? '0 : pcol + 1'b1;
                if (last_col) begin
                    row <= last_row ? '0 : prow + 1'b1;
                end else begin
                    row <= prow;
                end
                if (start) begin
                    state <= S_FILL;
                end else begin
                    unique case (state)
                        S_FILL: begin
                            if (prow == RW'(1) && last_col) begin
                                state <= S_RUN;
                            end
                        end
                        S_RUN: begin
                            if (last_row && last_col) begin
                                state <= S_FILL;
                            end
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/window_buffer.md
Name: window_buffer

Overview:
- Upstream neighbour of the 3x3 convolution stage: turns a raster-order 8-bit pixel stream into 3x3 sliding windows.
- Each window leaves as a 72-bit word that drives the convolution stage's ifmap input directly.
- Holds two full image rows in line buffers plus a 3x3 register window. Produces one window per accepted pixel once the window is fully inside the image ("valid" convolution, no padding).

Parameters:
IMG_W, 28, image width in pixels (>= 3)
IMG_H, 28, image height in pixels (>= 3)
PIX_W, 8, pixel width in bits (fixed at 8 to match conv stage)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
pix_in  input  8  incoming pixel, raster order (row-major, left to right)
pix_valid  input  1  pix_in is accepted this cycle
sof  input  1  start of frame; qualified by pix_valid; marks pix_in as pixel (0,0)
window  output  72  3x3 window; byte k = window[8k+7:8k], k = 3*r + c, r = 0 top row, c = 0 leftmost column
win_valid  output  1  window holds a new valid window this cycle (one-cycle pulse per window)
frame_done  output  1  one-cycle pulse, same cycle as the last window of a frame
busy  output  1  high while a frame is in progress (first pixel accepted, last not yet accepted)

Behaviour:
- Interface decided: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: window = 0, win_valid = 0, frame_done = 0, busy = 0, col = 0, row = 0, state = S_FILL.
  - Line-buffer contents are not reset and never affect a valid window.
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) give the position of the pixel accepted this cycle. Both advance only when pix_valid = 1.
  - col wraps to 0 after IMG_W-1 and row then increments.
  - After (IMG_H-1, IMG_W-1), both wrap to 0.
- Data path on each accepted pixel:
  - Line buffer 0 delays the pixel by IMG_W accepted pixels.
  - Line buffer 1 delays line buffer 0's output by IMG_W accepted pixels.
  - The 3x3 register window shifts left by one column. The new right column is (lb1_out, lb0_out, pix_in) for rows (0, 1, 2).
- With pix_valid = 0, nothing moves: counters, buffers and window hold, and win_valid = 0. Gaps of any length are allowed.
- Latency: window and win_valid are registered and appear in the cycle after the accepted pixel that completes the window.
- win_valid = 1 iff the previous cycle accepted a pixel with row >= 2 and col >= 2.
  - Exactly (IMG_W-2)*(IMG_H-2) windows per frame; 676 for 28x28.
- FSM:
  - S_FILL (row < 2, no windows): moves to S_RUN when the pixel at (1, IMG_W-1) is accepted.
  - S_RUN (windows emitted): returns to S_FILL when the pixel at (IMG_H-1, IMG_W-1) is accepted.
  - On that same final acceptance, frame_done pulses together with the last win_valid, in the following cycle.
- busy:
  - Set on any accepted pixel.
  - Cleared in the cycle frame_done pulses.
- sof:
  - sof & pix_valid forces this pixel to (0,0). Counters restart and the state goes to S_FILL.
  - Any partial frame is discarded: no frame_done, and no windows until the new row 2, col 2.
  - sof with pix_valid = 0 is ignored.
- Reset mid-frame: all outputs and counters return to reset values immediately. The next accepted pixel is (0,0).
- No backpressure: the downstream conv stage is combinational into a registered ReLU and always accepts. window holds its value between pulses.

Decomposition:
- Package cnn_pkg:
  - PIX_W = 8, WIN_TAPS = 9, WIN_W = PIX_W*WIN_TAPS = 72
  - pixel_t (8-bit)
  - state encoding S_FILL = 1'b0, S_RUN = 1'b1
  - The conv stage shares this package.
- Sub-module line_fifo #(DEPTH, WIDTH): a shift-enable delay line (register chain or circular RAM with one pointer), instantiated twice with DEPTH = IMG_W.
- Top keeps counters, FSM and 3x3 register window.

Test Plan:
1. IMG_W = IMG_H = 5; stream pixels 1..25 with pix_valid held high and sof on pixel 1. Required response:
   - First win_valid the cycle after pixel 13, with bytes k0..k8 = 1,2,3,6,7,8,11,12,13.
   - Last window bytes = 13,14,15,18,19,20,23,24,25, with frame_done high in the same cycle.
   - 9 win_valid pulses in total.
2. Same frame with pix_valid toggling 1,0,0,1,...: identical 9 windows in the same order. window and win_valid hold/zero during gaps; no spurious pulses.
3. Two back-to-back 5x5 frames, second frame = 101..125:
   - No window mixes frames.
   - Second frame's first window = 101,102,103,106,107,108,111,112,113.
   - Two frame_done pulses.
4. sof asserted again at pixel 17 of a 5x5 frame, restarting from value 201:
   - No frame_done for the aborted frame.
   - Next window = 201,202,203,206,207,208,211,212,213.
5. Assert rst_n = 0 asynchronously mid-cycle during S_RUN: window = 0, win_valid = 0, busy = 0 without a clock edge. After release, a full 5x5 frame yields exactly 9 correct windows.
6. Default 28x28 frame of a pseudo-random stream: 676 windows matching a reference model, with the last window at pixel index 783.
